// File: rtl/plab2_proc_muldiv_pkg.sv
// Shared definitions for the X-stage multiply/divide units.
// Holds the packed request/response message layout (func, a, b), the
// func-code constants, the iterative divider FSM state type and a small
// conditional-negate helper used for sign fix-up.
package plab2_proc_muldiv_pkg;

  // Message widths
  localparam int unsigned c_req_nbits  = 67;
  localparam int unsigned c_resp_nbits = 32;

  // Request field offsets: func[66:64], a[63:32], b[31:0]
  localparam int unsigned c_func_lsb   = 64;
  localparam int unsigned c_func_nbits = 3;
  localparam int unsigned c_a_lsb      = 32;
  localparam int unsigned c_b_lsb      = 0;
  localparam int unsigned c_data_nbits = 32;

  // Func codes
  localparam logic [2:0] c_func_mul  = 3'd0;
  localparam logic [2:0] c_func_div  = 3'd1;
  localparam logic [2:0] c_func_divu = 3'd2;
  localparam logic [2:0] c_func_rem  = 3'd3;
  localparam logic [2:0] c_func_remu = 3'd4;

  // Iterative divider: 32 iterations, counter runs 0..31
  localparam logic [4:0] c_div_cnt_last = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_t;

  // Two's-complement negate when neg is set, pass through otherwise.
  function automatic logic [31:0] f_cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/plab2_proc_IntDivIterCtrl.sv
// Control for the iterative divider: IDLE/CALC/DONE FSM plus the
// iteration counter.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   i_in_val      request valid
//   o_in_rdy      ready for a request (IDLE only)
//   o_out_val     result valid (DONE only)
//   i_out_rdy     consumer accepts the result
//   o_load        request accepted this cycle: datapath latches operands
//   o_calc        datapath performs one restoring-division step
//   o_last        final step: datapath also latches the fixed-up result
module plab2_proc_IntDivIterCtrl
  import plab2_proc_muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_in_val,
  output logic o_in_rdy,
  output logic o_out_val,
  input  logic i_out_rdy,
  output logic o_load,
  output logic o_calc,
  output logic o_last
);

  div_state_t r_state;
  div_state_t w_state_next;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_in_rdy     = 1'b0;
    o_out_val    = 1'b0;
    o_load       = 1'b0;
    o_calc       = 1'b0;
    o_last       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_in_rdy = 1'b1;
        if (i_in_val) begin
          o_load       = 1'b1;
          w_cnt_next   = 5'd0;
          w_state_next = StCalc;
        end
      end
      StCalc: begin
        o_calc = 1'b1;
        if (r_cnt == c_div_cnt_last) begin
          o_last       = 1'b1;
          w_cnt_next   = 5'd0;
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + 5'd1;
        end
      end
      StDone: begin
        // No accept here: in_rdy stays independent of out_rdy.
        o_out_val = 1'b1;
        if (i_out_rdy) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/plab2_proc_int_div_iter.sv
// Iterative 32-bit integer divide/remainder unit (div, divu, rem, remu).
// Fixed latency: 32 restoring-division steps on operand magnitudes, sign
// fix-up on entry to DONE, registered result held until out_rdy.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   in_val/in_rdy/in_msg     request handshake; in_msg = {func, a, b}
//   out_val/out_rdy/out_msg  response handshake; out_msg = quotient or remainder
module plab2_proc_int_div_iter
  import plab2_proc_muldiv_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [c_req_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_nbits-1:0]     out_msg
);

  logic w_load;
  logic w_calc;
  logic w_last;

  plab2_proc_IntDivIterCtrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .i_in_val  (in_val),
    .o_in_rdy  (in_rdy),
    .o_out_val (out_val),
    .i_out_rdy (out_rdy),
    .o_load    (w_load),
    .o_calc    (w_calc),
    .o_last    (w_last)
  );

  // Request unpack
  logic [c_func_nbits-1:0] w_func;
  logic [c_data_nbits-1:0] w_a;
  logic [c_data_nbits-1:0] w_b;
  logic                    w_signed;
  logic [31:0]             w_a_mag;
  logic [31:0]             w_b_mag;

  assign w_func   = in_msg[c_func_lsb +: c_func_nbits];
  assign w_a      = in_msg[c_a_lsb +: c_data_nbits];
  assign w_b      = in_msg[c_b_lsb +: c_data_nbits];
  assign w_signed = (w_func == c_func_div) || (w_func == c_func_rem);
  assign w_a_mag  = f_cond_neg(w_a, w_signed & w_a[31]);
  assign w_b_mag  = f_cond_neg(w_b, w_signed & w_b[31]);

  // Datapath state
  logic [2:0]              r_func;
  logic [31:0]             r_a_mag;
  logic [31:0]             r_b;
  logic [63:0]             r_rq;     // {remainder, quotient} shift register
  logic                    r_qneg;
  logic                    r_rneg;
  logic                    r_dbz;
  logic [c_resp_nbits-1:0] r_out;

  // One restoring step. Shifted remainder can reach 33 bits, so the trial
  // compare uses the upper 33 bits; a kept difference is always < divisor.
  logic [32:0] w_upper;
  logic        w_fits;
  logic [31:0] w_sub;
  logic [63:0] w_rq_next;

  assign w_upper   = r_rq[63:31];
  assign w_fits    = (w_upper >= {1'b0, r_b});
  assign w_sub     = w_upper[31:0] - r_b;
  assign w_rq_next = w_fits ? {w_sub, r_rq[30:0], 1'b1}
                            : {w_upper[31:0], r_rq[30:0], 1'b0};

  // Sign fix-up and func select, evaluated on the final step
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_a_orig;
  logic [31:0] w_result;

  always_comb begin
    w_q      = f_cond_neg(w_rq_next[31:0], r_qneg);
    w_r      = f_cond_neg(w_rq_next[63:32], r_rneg);
    // Re-applying the dividend sign to |a| recovers a exactly.
    w_a_orig = f_cond_neg(r_a_mag, r_rneg);
    w_result = '0;
    case (r_func)
      c_func_div,
      c_func_divu: w_result = r_dbz ? 32'hFFFF_FFFF : w_q;
      c_func_rem,
      c_func_remu: w_result = r_dbz ? w_a_orig : w_r;
      c_func_mul:  w_result = '0;
      default:     w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_func  <= 3'd0;
      r_a_mag <= 32'd0;
      r_b     <= 32'd0;
      r_rq    <= 64'd0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dbz   <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_load) begin
        r_func  <= w_func;
        r_a_mag <= w_a_mag;
        r_b     <= w_b_mag;
        r_rq    <= {32'd0, w_a_mag};
        r_qneg  <= w_signed & (w_a[31] ^ w_b[31]);
        r_rneg  <= w_signed & w_a[31];
        r_dbz   <= (w_b == 32'd0);
      end
      if (w_calc) begin
        r_rq <= w_rq_next;
      end
      if (w_last) begin
        r_out <= w_result;
      end
    end
  end

  assign out_msg = r_out;

endmodule

// File: doc/plab2_proc_int_div_iter.md
# plab2_proc_int_div_iter

Iterative 32-bit integer divide/remainder unit for the X stage of the 5-stage pipelined processor, next to the variable-latency multiplier. It takes the same packed mul/div request message the D stage already builds and returns a 32-bit result over a val/rdy handshake. The X-stage result mux selects this unit's output, and the stall controller holds the pipeline while the unit is busy.

## Interface
- p_nbits, 32, operand width. Only 32 is supported.
- clk  input  1  clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  request valid.
- in_rdy  output  1  unit can accept a request.
- in_msg  input  67  request: func[66:64], a[63:32] (dividend), b[31:0] (divisor).
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- out_msg  output  32  quotient or remainder.

## Operation
- Func codes:
  - 3'd1 div: signed quotient.
  - 3'd2 divu: unsigned quotient.
  - 3'd3 rem: signed remainder.
  - 3'd4 remu: unsigned remainder.
  - Codes 0 and 5–7 are illegal: out_msg = 0, same latency as a legal request.
- Handshake:
  - A request transfers when in_val && in_rdy.
  - A response transfers when out_val && out_rdy.
  - in_rdy does not depend combinationally on out_rdy.
- FSM states IDLE, CALC, DONE. Reset state is IDLE.
  - IDLE: in_rdy=1. On a request, latch the operands and go to CALC.
  - CALC: 32 iterations. Counter counts 0..31. Go to DONE when the counter reaches 31.
  - DONE: out_val=1. On out_rdy go to IDLE. No request is accepted in the same cycle.
- Latching in IDLE:
  - Register the func code.
  - Register |a| and |b| for signed ops (raw values for unsigned ops).
  - Register quotient sign = a[31]^b[31] and remainder sign = a[31] (signed ops only).
  - Register a divide-by-zero flag (b==0).
- CALC is restoring division over a 64-bit remainder/quotient shift register. Each cycle:
  - Shift left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep it and set quotient bit 0.
- Signs are fixed up on entry to DONE:
  - Negate the quotient if its sign is set.
  - Negate the remainder if the dividend was negative.
  - The remainder therefore takes the sign of the dividend.
- Divide by zero overrides the computed result, for every op and every sign:
  - div/divu: quotient = 32'hFFFFFFFF.
  - rem/remu: remainder = a, unmodified.
- Overflow, div 32'h80000000 / 32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0. This falls out of the magnitude algorithm with no special case.

## Timing
- Reset values: in_rdy=1, out_val=0, out_msg=0. Counter=0, state=IDLE.
- Request accepted at edge N → out_val=1 in cycle N+33. Fixed latency, independent of operand values.
- out_msg is registered and holds stable while out_val && !out_rdy, for any number of cycles.
- in_rdy=0 in CALC and DONE. Throughput: one operation per 34 cycles, best case.
- A reset asserted mid-CALC or mid-DONE immediately forces IDLE and the reset values. The in-flight result is discarded and nothing is emitted afterwards.
- in_val during CALC or DONE is ignored. in_msg is sampled only at the accept edge.

## Structure
- The shared package (plab2_proc_muldiv_pkg) holds:
  - Func code constants c_func_mul=0, c_func_div=1, c_func_divu=2, c_func_rem=3, c_func_remu=4.
  - Message width constants c_req_nbits=67 and c_resp_nbits=32.
  - Field offsets.
- The multiplier message pack/unpack uses the same package.
- Split into control and datapath:
  - plab2_proc_IntDivIterCtrl: FSM and counter.
  - Top-level datapath: operand and sign registers, shift register, subtractor, fixup negators, output register.
- Reuse the existing register and mux library cells.

## Test plan
- divu a=100, b=7 → out_msg=14, out_val in cycle N+33. remu with the same operands → 2.
- div a=-7 (32'hFFFFFFF9), b=2 → 32'hFFFFFFFD (-3). rem with the same operands → 32'hFFFFFFFF (-1).
- div a=32'h80000000, b=32'hFFFFFFFF → 32'h80000000. rem with the same operands → 0.
- Divide by zero, a=32'hFFFFFFF0, b=0:
  - divu → 32'hFFFFFFFF.
  - div → 32'hFFFFFFFF.
  - rem → 32'hFFFFFFF0.
  - func=6 → 0.
- Backpressure and back-to-back:
  - Hold out_rdy=0 for 5 cycles after out_val rises → out_msg stable, in_rdy=0 throughout.
  - Release out_rdy with in_val held high → next request accepted the cycle after the output transfer.
- Reset pulse at cycle 10 of CALC → next cycle in_rdy=1, out_val=0. A following divu 9/3 returns 3 with full 33-cycle latency.
